// File: rtl/trade_tone_writer_pkg.sv
// Shared definitions for the trade tone writer: sample width, FSM state
// encodings, default tone constants and the sample level helper.
package trade_tone_writer_pkg;

    localparam int SAMPLE_W   = 32;
    localparam int PRICE_HI_W = 4;

    localparam int                  DEF_HALF_BASE    = 24;
    localparam int                  DEF_TONE_SAMPLES = 4800;
    localparam logic [SAMPLE_W-1:0] DEF_AMPLITUDE    = 32'h1000_0000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } tone_state_e;

    // Square-wave level for a given phase: phase 0 is the positive peak,
    // phase 1 the two's complement of it.
    function automatic logic [SAMPLE_W-1:0] tone_level(
        input logic                phase,
        input logic [SAMPLE_W-1:0] amp
    );
        logic [SAMPLE_W-1:0] level;
        if (phase) begin
            level = (~amp) + {{(SAMPLE_W-1){1'b0}}, 1'b1};
        end else begin
            level = amp;
        end
        return level;
    endfunction

endpackage

// File: rtl/trade_tone_osc.sv
// Half-period oscillator for the trade tone. Holds the price-derived
// half-period length, counts accepted samples within the current half
// period and toggles the square-wave phase at each half-period boundary.
module trade_tone_osc
    import trade_tone_writer_pkg::*;
#(
    parameter int HALF_BASE = DEF_HALF_BASE,
    parameter int HL_W      = $clog2(HALF_BASE + 16)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [PRICE_HI_W-1:0] price_hi_i,
    input  logic                  advance_i,
    output logic                  phase_o,
    output logic                  wrap_o
);

    logic [HL_W-1:0] half_len_q;
    logic [HL_W-1:0] half_len_d;
    logic [HL_W-1:0] half_cnt_q;
    logic [HL_W-1:0] half_cnt_d;
    logic            phase_q;
    logic            phase_d;
    logic            half_done_s;

    // Detect the last sample of the current half period.
    always_comb begin
        half_done_s = (half_cnt_q == (half_len_q - {{(HL_W-1){1'b0}}, 1'b1}));
    end

    // Next-state: a load restarts the waveform (and wins over advance),
    // an advance steps the half-period counter and flips phase on wrap.
    always_comb begin
        half_len_d = half_len_q;
        half_cnt_d = half_cnt_q;
        phase_d    = phase_q;
        if (load_i) begin
            half_len_d = HL_W'(HALF_BASE) + HL_W'(price_hi_i);
            half_cnt_d = {HL_W{1'b0}};
            phase_d    = 1'b0;
        end else if (advance_i) begin
            if (half_done_s) begin
                half_cnt_d = {HL_W{1'b0}};
                phase_d    = ~phase_q;
            end else begin
                half_cnt_d = half_cnt_q + {{(HL_W-1){1'b0}}, 1'b1};
            end
        end else begin
            half_cnt_d = half_cnt_q;
        end
    end

    // Oscillator state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            half_len_q <= {HL_W{1'b0}};
            half_cnt_q <= {HL_W{1'b0}};
            phase_q    <= 1'b0;
        end else begin
            half_len_q <= half_len_d;
            half_cnt_q <= half_cnt_d;
            phase_q    <= phase_d;
        end
    end

    assign phase_o = phase_q;
    assign wrap_o  = advance_i & ~load_i & half_done_s;

endmodule

// File: rtl/trade_tone_writer.sv
// Trade tone writer: on each play_pulse emits a fixed-length square-wave
// tone into the codec DAC FIFO, pitch chosen by the upper price nibble.
// Samples are presented on registered aud_* and consumed on audio_write.
module trade_tone_writer
    import trade_tone_writer_pkg::*;
#(
    parameter int                  HALF_BASE    = DEF_HALF_BASE,
    parameter int                  TONE_SAMPLES = DEF_TONE_SAMPLES,
    parameter logic [SAMPLE_W-1:0] AMPLITUDE    = DEF_AMPLITUDE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                play_pulse,
    input  logic [7:0]          trade_price,
    input  logic                audio_allowed,
    output logic                audio_write,
    output logic [SAMPLE_W-1:0] aud_left,
    output logic [SAMPLE_W-1:0] aud_right,
    output logic                busy
);

    localparam int               CNT_W    = (TONE_SAMPLES > 1) ? $clog2(TONE_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TONE_SAMPLES - 1);

    tone_state_e         state_q;
    tone_state_e         state_d;
    logic [CNT_W-1:0]    sample_cnt_q;
    logic [CNT_W-1:0]    sample_cnt_d;
    logic [SAMPLE_W-1:0] aud_q;
    logic [SAMPLE_W-1:0] aud_d;
    logic                busy_q;
    logic                busy_d;

    logic                accept_s;
    logic                last_s;
    logic                osc_load_s;
    logic                osc_adv_s;
    logic                osc_phase_s;
    logic                osc_wrap_s;
    logic                next_phase_s;
    logic                price_lo_unused_s;

    // Only the upper price nibble sets the pitch.
    assign price_lo_unused_s = ^trade_price[3:0];

    trade_tone_osc #(
        .HALF_BASE (HALF_BASE)
    ) u_osc (
        .clk        (clk),
        .reset      (reset),
        .load_i     (osc_load_s),
        .price_hi_i (trade_price[7:4]),
        .advance_i  (osc_adv_s),
        .phase_o    (osc_phase_s),
        .wrap_o     (osc_wrap_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a pulse always (re)starts the tone, even on the last
    // accepted sample; otherwise the last acceptance returns to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (play_pulse) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (play_pulse) begin
                    state_d = ST_PLAY;
                end else if (last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: handshake decode and oscillator control.
    always_comb begin
        accept_s   = 1'b0;
        last_s     = 1'b0;
        osc_load_s = play_pulse;
        osc_adv_s  = 1'b0;
        case (state_q)
            ST_PLAY: begin
                accept_s  = audio_allowed;
                last_s    = audio_allowed & (sample_cnt_q == LAST_IDX);
                osc_adv_s = audio_allowed;
            end
            ST_IDLE: begin
                accept_s  = 1'b0;
                last_s    = 1'b0;
                osc_adv_s = 1'b0;
            end
            default: begin
                accept_s  = 1'b0;
                last_s    = 1'b0;
                osc_adv_s = 1'b0;
            end
        endcase
    end

    // Sample counter, next output sample and busy flag. Stalls hold all.
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        aud_d        = aud_q;
        next_phase_s = osc_phase_s ^ osc_wrap_s;
        busy_d       = (state_d == ST_PLAY);
        if (play_pulse) begin
            sample_cnt_d = {CNT_W{1'b0}};
            aud_d        = tone_level(1'b0, AMPLITUDE);
        end else if (last_s) begin
            sample_cnt_d = {CNT_W{1'b0}};
            aud_d        = {SAMPLE_W{1'b0}};
        end else if (accept_s) begin
            sample_cnt_d = sample_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            aud_d        = tone_level(next_phase_s, AMPLITUDE);
        end else begin
            sample_cnt_d = sample_cnt_q;
            aud_d        = aud_q;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt_q <= {CNT_W{1'b0}};
            aud_q        <= {SAMPLE_W{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            aud_q        <= aud_d;
            busy_q       <= busy_d;
        end
    end

    assign audio_write = accept_s;
    assign aud_left    = aud_q;
    assign aud_right   = aud_q;
    assign busy        = busy_q;

endmodule
